// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common-data-bus arbiter and its per-producer FIFOs.
package cdb_arbiter_pkg;

    localparam int CDB_SRC_NUM       = 3;
    localparam int CDB_FIFO_DEPTH    = 4;
    localparam int CDB_ROB_INDEX_BIT = 5;
    localparam int CDB_DATA_W        = 32;

    typedef enum logic [1:0] {
        CDB_SRC_ALU = 2'd0,
        CDB_SRC_LSB = 2'd1,
        CDB_SRC_BR  = 2'd2
    } cdb_src_e;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int cdb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small per-producer result FIFO; full/empty are decoded from the occupancy register only.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = CDB_FIFO_DEPTH,
    parameter int WIDTH = CDB_ROB_INDEX_BIT + CDB_DATA_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = cdb_idx_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             update_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    // A push into a full FIFO is a producer protocol error and is dropped here.
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign update_s  = rst_in && rdy_in && !clear;
    assign head      = mem_r[rd_ptr_r];

    // Pointer and occupancy state: reset > freeze > flush > push/pop.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (!rdy_in) begin
            rd_ptr_r <= rd_ptr_r;
            wr_ptr_r <= wr_ptr_r;
            count_r  <= count_r;
        end else if (clear) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only observed while the slot is occupied.
    always_ff @(posedge clk_in) begin
        if (update_s && push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that drains per-producer FIFOs onto a single registered common data bus.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC       = CDB_SRC_NUM,
    parameter int FIFO_DEPTH    = CDB_FIFO_DEPTH,
    parameter int ROB_INDEX_BIT = CDB_ROB_INDEX_BIT
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             rdy_in,
    input  logic                             clear,
    input  logic [NUM_SRC-1:0]               src_valid,
    input  logic [NUM_SRC*ROB_INDEX_BIT-1:0] src_rob_id,
    input  logic [NUM_SRC*32-1:0]            src_val,
    output logic [NUM_SRC-1:0]               src_full,
    output logic                             cdb_req,
    output logic [ROB_INDEX_BIT-1:0]         cdb_rob_id,
    output logic [31:0]                      cdb_val
);

    localparam int EW    = ROB_INDEX_BIT + 32;
    localparam int SRC_W = cdb_idx_w(NUM_SRC);

    logic [EW-1:0]      head_s [NUM_SRC];
    logic [NUM_SRC-1:0] empty_s;
    logic [NUM_SRC-1:0] pop_s;
    logic [SRC_W-1:0]   rr_ptr_r;
    logic [SRC_W-1:0]   win_s;
    logic [SRC_W-1:0]   cand_s;
    logic               found_s;
    logic [EW-1:0]      win_head_s;

    function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] p);
        if (p == SRC_W'(NUM_SRC - 1)) begin
            return {SRC_W{1'b0}};
        end else begin
            return p + SRC_W'(1);
        end
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign pop_s[i] = found_s && (win_s == SRC_W'(i));

        cdb_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (EW)
        ) u_fifo (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .rdy_in (rdy_in),
            .clear  (clear),
            .push   (src_valid[i]),
            .din    ({src_rob_id[i*ROB_INDEX_BIT +: ROB_INDEX_BIT], src_val[i*32 +: 32]}),
            .pop    (pop_s[i]),
            .head   (head_s[i]),
            .empty  (empty_s[i]),
            .full   (src_full[i])
        );
    end

    // Grant: walk the sources starting at rr_ptr and take the first non-empty head.
    always_comb begin
        win_s   = rr_ptr_r;
        found_s = 1'b0;
        cand_s  = rr_ptr_r;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found_s && !empty_s[cand_s]) begin
                win_s   = cand_s;
                found_s = 1'b1;
            end else begin
                win_s   = win_s;
            end
            cand_s = rr_next(cand_s);
        end
    end

    assign win_head_s = head_s[win_s];

    // Bus registers and rotation pointer; idle cycles keep the last tag/value on the bus.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cdb_req    <= 1'b0;
            cdb_rob_id <= {ROB_INDEX_BIT{1'b0}};
            cdb_val    <= 32'h0000_0000;
            rr_ptr_r   <= {SRC_W{1'b0}};
        end else if (!rdy_in) begin
            cdb_req    <= cdb_req;
            rr_ptr_r   <= rr_ptr_r;
        end else if (clear) begin
            cdb_req    <= 1'b0;
            rr_ptr_r   <= {SRC_W{1'b0}};
        end else if (found_s) begin
            cdb_req    <= 1'b1;
            cdb_rob_id <= win_head_s[EW-1:32];
            cdb_val    <= win_head_s[31:0];
            rr_ptr_r   <= rr_next(win_s);
        end else begin
            cdb_req    <= 1'b0;
            rr_ptr_r   <= rr_ptr_r;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed table, corner-case sequences and a randomized run against a queue model.
module tb_cdb_arbiter;

    localparam int NS  = 3;
    localparam int DEP = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic [2:0]  src_valid;
    logic [14:0] src_rob_id;
    logic [95:0] src_val;
    logic [2:0]  src_full;
    logic        cdb_req;
    logic [4:0]  cdb_rob_id;
    logic [31:0] cdb_val;

    always #5 clk_in = ~clk_in;

    cdb_arbiter dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear      (clear),
        .src_valid  (src_valid),
        .src_rob_id (src_rob_id),
        .src_val    (src_val),
        .src_full   (src_full),
        .cdb_req    (cdb_req),
        .cdb_rob_id (cdb_rob_id),
        .cdb_val    (cdb_val)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: one queue per producer plus the bus registers and rotation start.
    logic [36:0] mq [NS][$];
    int          m_rr  = 0;
    logic        m_req = 1'b0;
    logic [4:0]  m_rob = 5'd0;
    logic [31:0] m_val = 32'd0;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        clr;
        logic [2:0]  valid;
        logic [14:0] robs;
        logic [95:0] vals;
        logic        exp_req;
        logic [4:0]  exp_rob;
        logic [31:0] exp_val;
        logic [2:0]  exp_full;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic r, input logic c, input logic [2:0] v,
                                input logic [14:0] robs, input logic [95:0] vals,
                                input logic er, input logic [4:0] eb, input logic [31:0] ev);
        vec_t t;
        t.rst = r; t.rdy = 1'b1; t.clr = c; t.valid = v; t.robs = robs; t.vals = vals;
        t.exp_req = er; t.exp_rob = eb; t.exp_val = ev; t.exp_full = 3'b000;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic rd, input logic c, input logic [2:0] v,
                          input logic [14:0] robs, input logic [95:0] vals);
        rst_in = r; rdy_in = rd; clear = c; src_valid = v; src_rob_id = robs; src_val = vals;
    endtask

    task automatic model_step();
        logic [2:0]  fp;
        int          win;
        int          j;
        logic [36:0] e;
        if (!rst_in) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            m_rr = 0; m_req = 1'b0; m_rob = 5'd0; m_val = 32'd0;
        end else if (!rdy_in) begin
            m_req = m_req;
        end else if (clear) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            m_rr = 0; m_req = 1'b0;
        end else begin
            for (int i = 0; i < NS; i++) fp[i] = (mq[i].size() == DEP);
            win = -1;
            for (int k = 0; k < NS; k++) begin
                j = (m_rr + k) % NS;
                if (win < 0 && mq[j].size() != 0) win = j;
            end
            if (win >= 0) begin
                e = mq[win].pop_front();
                m_req = 1'b1; m_rob = e[36:32]; m_val = e[31:0]; m_rr = (win + 1) % NS;
            end else begin
                m_req = 1'b0;
            end
            for (int i = 0; i < NS; i++)
                if (src_valid[i] && !fp[i]) mq[i].push_back({src_rob_id[i*5 +: 5], src_val[i*32 +: 32]});
        end
    endtask

    task automatic cycle();
        logic [2:0] ef;
        model_step();
        @(posedge clk_in);
        #1;
        for (int i = 0; i < NS; i++) ef[i] = (mq[i].size() == DEP);
        check("model_req", {63'd0, cdb_req}, {63'd0, m_req});
        check("model_rob", {59'd0, cdb_rob_id}, {59'd0, m_rob});
        check("model_val", {32'd0, cdb_val}, {32'd0, m_val});
        check("model_full", {61'd0, src_full}, {61'd0, ef});
    endtask

    initial begin
        logic [2:0] v;
        logic [2:0] fpre;
        logic       r, rd, cl;
        logic       pv [NS];
        logic [4:0] prob [NS];
        logic [31:0] pval [NS];
        int         k_push, lsb_seen;
        logic       saw_full0;

        tbl[0]  = mk(1'b0, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, 5'd0, 32'h0);
        tbl[1]  = mk(1'b0, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, 5'd0, 32'h0);
        tbl[2]  = mk(1'b1, 1'b0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 32'h0);
        tbl[3]  = mk(1'b1, 1'b0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 32'h0);
        tbl[4]  = mk(1'b1, 1'b0, 3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h1234}, 1'b0, 5'd0, 32'h0);
        tbl[5]  = mk(1'b1, 1'b0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd5, 32'h1234);
        tbl[6]  = mk(1'b1, 1'b0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd5, 32'h1234);
        tbl[7]  = mk(1'b1, 1'b1, 3'b000, 15'd0, 96'd0, 1'b0, 5'd5, 32'h1234);
        tbl[8]  = mk(1'b1, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC3, 32'hB2, 32'hA1}, 1'b0, 5'd5, 32'h1234);
        tbl[9]  = mk(1'b1, 1'b0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd1, 32'hA1);
        tbl[10] = mk(1'b1, 1'b0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd2, 32'hB2);
        tbl[11] = mk(1'b1, 1'b0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd3, 32'hC3);
        tbl[12] = mk(1'b1, 1'b0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd3, 32'hC3);
        tbl[13] = mk(1'b1, 1'b0, 3'b011, {5'd0, 5'd9, 5'd8}, {32'h0, 32'h99, 32'h88}, 1'b0, 5'd3, 32'hC3);
        tbl[14] = mk(1'b1, 1'b0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd8, 32'h88);
        tbl[15] = mk(1'b1, 1'b0, 3'b000, 15'd0, 96'd0, 1'b1, 5'd9, 32'h99);
        tbl[16] = mk(1'b1, 1'b0, 3'b000, 15'd0, 96'd0, 1'b0, 5'd9, 32'h99);

        set_in(1'b0, 1'b1, 1'b0, 3'b000, 15'd0, 96'd0);
        for (int n = 0; n < 17; n++) begin
            set_in(tbl[n].rst, tbl[n].rdy, tbl[n].clr, tbl[n].valid, tbl[n].robs, tbl[n].vals);
            cycle();
            check($sformatf("tbl%0d_req", n), {63'd0, cdb_req}, {63'd0, tbl[n].exp_req});
            check($sformatf("tbl%0d_rob", n), {59'd0, cdb_rob_id}, {59'd0, tbl[n].exp_rob});
            check($sformatf("tbl%0d_val", n), {32'd0, cdb_val}, {32'd0, tbl[n].exp_val});
            check($sformatf("tbl%0d_full", n), {61'd0, src_full}, {61'd0, tbl[n].exp_full});
        end

        // LSB pushes five results while ALU and BRANCH keep their FIFOs saturated.
        k_push = 0; lsb_seen = 0; saw_full0 = 1'b0;
        for (int c = 0; c < 80 && lsb_seen < 5; c++) begin
            v[0] = !src_full[0];
            v[2] = !src_full[2];
            v[1] = (k_push < 5) && !src_full[1];
            set_in(1'b1, 1'b1, 1'b0, v, {5'd21, 5'(10 + k_push), 5'd20},
                   {32'hB2B2_0000 + c, 32'hB000_0000 + k_push, 32'hA000_0000 + c});
            cycle();
            if (v[1]) k_push++;
            if (src_full[0]) saw_full0 = 1'b1;
            if (cdb_req && cdb_rob_id >= 5'd10 && cdb_rob_id < 5'd15) begin
                check("lsb_order", {59'd0, cdb_rob_id}, 64'(10 + lsb_seen));
                check("lsb_val", {32'd0, cdb_val}, {32'd0, 32'hB000_0000 + lsb_seen});
                lsb_seen++;
            end
        end
        check("lsb_all_broadcast", 64'(lsb_seen), 64'd5);
        check("alu_reached_full", {63'd0, saw_full0}, 64'd1);
        set_in(1'b1, 1'b1, 1'b0, 3'b000, 15'd0, 96'd0);
        for (int c = 0; c < 16; c++) cycle();

        // Flush with three queued entries and a simultaneous ALU push.
        set_in(1'b1, 1'b1, 1'b0, 3'b111, {5'd27, 5'd26, 5'd25}, {32'h27, 32'h26, 32'h25});
        cycle();
        set_in(1'b1, 1'b1, 1'b1, 3'b001, {5'd0, 5'd0, 5'd30}, {32'h0, 32'h0, 32'h30});
        cycle();
        check("flush_req", {63'd0, cdb_req}, 64'd0);
        set_in(1'b1, 1'b1, 1'b0, 3'b000, 15'd0, 96'd0);
        for (int c = 0; c < 6; c++) begin
            cycle();
            check("flush_no_bcast", {63'd0, cdb_req}, 64'd0);
        end

        // Freeze while rob 7 is on the bus and rob 8 waits behind it.
        set_in(1'b1, 1'b1, 1'b0, 3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h77});
        cycle();
        set_in(1'b1, 1'b1, 1'b0, 3'b001, {5'd0, 5'd0, 5'd8}, {32'h0, 32'h0, 32'h88});
        cycle();
        check("prefreeze_rob", {59'd0, cdb_rob_id}, 64'd7);
        set_in(1'b1, 1'b0, 1'b0, 3'b111, {5'd1, 5'd2, 5'd3}, {32'h1, 32'h2, 32'h3});
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("freeze_req", {63'd0, cdb_req}, 64'd1);
            check("freeze_rob", {59'd0, cdb_rob_id}, 64'd7);
            check("freeze_val", {32'd0, cdb_val}, 64'h77);
        end
        set_in(1'b1, 1'b1, 1'b0, 3'b000, 15'd0, 96'd0);
        cycle();
        check("resume_rob", {59'd0, cdb_rob_id}, 64'd8);
        check("resume_req", {63'd0, cdb_req}, 64'd1);
        cycle();
        check("resume_idle", {63'd0, cdb_req}, 64'd0);

        // Randomized producers that hold results on full, with occasional protocol errors.
        for (int i = 0; i < NS; i++) begin pv[i] = 1'b0; prob[i] = 5'd0; pval[i] = 32'd0; end
        for (int c = 0; c < 1500; c++) begin
            r  = ($urandom_range(0, 99) != 0);
            rd = ($urandom_range(0, 9) != 0);
            cl = ($urandom_range(0, 32) == 0);
            fpre = src_full;
            for (int i = 0; i < NS; i++) begin
                if (!pv[i] && $urandom_range(0, 3) != 0) begin
                    pv[i] = 1'b1; prob[i] = 5'($urandom); pval[i] = $urandom;
                end
                v[i] = pv[i] && (!fpre[i] || $urandom_range(0, 7) == 0);
            end
            set_in(r, rd, cl, v, {prob[2], prob[1], prob[0]}, {pval[2], pval[1], pval[0]});
            cycle();
            for (int i = 0; i < NS; i++)
                if (v[i] && rd && (!r || cl || !fpre[i])) pv[i] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
